// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, format encoding and the
// decoded-field bundle carried through the decode stage buffers.
package mips_pkg;

  localparam int INST_W = 32;
  localparam int OPC_W  = 6;
  localparam int REG_W  = 5;
  localparam int FUNC_W = 6;
  localparam int JT_W   = 26;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  shamt;
    logic [FUNC_W-1:0] funct;
    logic [JT_W-1:0]   jtarget;
    fmt_e              fmt;
  } dec_fields_t;

  localparam dec_fields_t DEC_ZERO = '{
    opcode:  6'd0,
    rs:      5'd0,
    rt:      5'd0,
    rd:      5'd0,
    shamt:   5'd0,
    funct:   6'd0,
    jtarget: 26'd0,
    fmt:     FMT_R
  };

  // Format 3 is never produced: anything that is not R or J is I.
  function automatic fmt_e fmt_of(input logic [OPC_W-1:0] op);
    case (op)
      OP_RTYPE:     return FMT_R;
      OP_J, OP_JAL: return FMT_J;
      default:      return FMT_I;
    endcase
  endfunction

endpackage

// File: rtl/inst_field_extract.sv
// Combinational MIPS field slicer and immediate extender; every field is
// driven for every format so downstream never sees undriven bits.
module inst_field_extract
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [INST_W-1:0] i_inst,
  output dec_fields_t       o_fields,
  output logic [DATA_W-1:0] o_imm_ext
);

  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_sext;

  assign w_zext = DATA_W'(i_inst[15:0]);
  assign w_sext = DATA_W'($signed(i_inst[15:0]));

  always_comb begin
    o_fields         = DEC_ZERO;
    o_fields.opcode  = i_inst[31:26];
    o_fields.rs      = i_inst[25:21];
    o_fields.rt      = i_inst[20:16];
    o_fields.rd      = i_inst[15:11];
    o_fields.shamt   = i_inst[10:6];
    o_fields.funct   = i_inst[5:0];
    o_fields.jtarget = i_inst[25:0];
    o_fields.fmt     = fmt_of(i_inst[31:26]);
  end

  // Logical immediates zero-extend; lui shifts into the upper half (truncated when DATA_W is 16).
  always_comb begin
    case (i_inst[31:26])
      OP_ANDI, OP_ORI, OP_XORI: o_imm_ext = w_zext;
      OP_LUI:                   o_imm_ext = w_zext << 16;
      default:                  o_imm_ext = w_sext;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// Registered, valid/ready decode stage: decodes ahead of the buffer so both the
// output register and the optional skid register hold already-decoded fields.
module inst_decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] imm_ext,
  output logic [25:0]       jtarget,
  output logic [1:0]        fmt
);

  dec_fields_t       w_dec;
  logic [DATA_W-1:0] w_imm;
  logic              w_in_fire;

  logic              r_out_valid;
  dec_fields_t       r_out_f;
  logic [DATA_W-1:0] r_out_imm;

  inst_field_extract #(.DATA_W(DATA_W)) u_extract (
    .i_inst    (inst),
    .o_fields  (w_dec),
    .o_imm_ext (w_imm)
  );

  assign w_in_fire = in_valid && in_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic              r_skid_valid;
      logic              r_in_ready;
      dec_fields_t       r_skid_f;
      logic [DATA_W-1:0] r_skid_imm;

      assign in_ready = r_in_ready;

      // in_ready is the registered inverse of next skid occupancy, so input is never taken while the skid is full.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_out_valid  <= 1'b0;
          r_out_f      <= DEC_ZERO;
          r_out_imm    <= '0;
          r_skid_valid <= 1'b0;
          r_skid_f     <= DEC_ZERO;
          r_skid_imm   <= '0;
          r_in_ready   <= 1'b0;
        end else if (flush) begin
          r_out_valid  <= 1'b0;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else if (!r_out_valid || out_ready) begin
          r_in_ready <= 1'b1;
          if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out_f      <= r_skid_f;
            r_out_imm    <= r_skid_imm;
            r_skid_valid <= 1'b0;
          end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_f     <= w_dec;
            r_out_imm   <= w_imm;
          end else begin
            r_out_valid <= 1'b0;
          end
        end else if (w_in_fire) begin
          r_skid_valid <= 1'b1;
          r_skid_f     <= w_dec;
          r_skid_imm   <= w_imm;
          r_in_ready   <= 1'b0;
        end else begin
          r_in_ready <= !r_skid_valid;
        end
      end
    end else begin : g_noskid
      assign in_ready = !r_out_valid || out_ready;

      // Single output register: loads whenever it is empty or being drained.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_out_valid <= 1'b0;
          r_out_f     <= DEC_ZERO;
          r_out_imm   <= '0;
        end else if (flush) begin
          r_out_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
          r_out_valid <= w_in_fire;
          if (w_in_fire) begin
            r_out_f   <= w_dec;
            r_out_imm <= w_imm;
          end
        end
      end
    end
  endgenerate

  assign out_valid = r_out_valid;
  assign opcode    = r_out_f.opcode;
  assign rs        = r_out_f.rs;
  assign rt        = r_out_f.rt;
  assign rd        = r_out_f.rd;
  assign shamt     = r_out_f.shamt;
  assign funct     = r_out_f.funct;
  assign jtarget   = r_out_f.jtarget;
  assign fmt       = r_out_f.fmt;
  assign imm_ext   = r_out_imm;

endmodule
